// File: rtl/s_wb_sched_pkg.sv
// s_wb_sched_pkg -- shared construction constants for the scalar writeback
// scheduler (Cray-XMP S register file writer).
//   - default data / address / unit-select / latency field widths
//   - reset polarity of the synchronous reset input
// Imported by s_wb_chain and s_wb_sched.
package s_wb_sched_pkg;

    localparam int WIDTH_DEF    = 64;
    localparam int LOGDEPTH_DEF = 3;
    localparam int NUM_FU_DEF   = 4;
    localparam int LOGFU_DEF    = 2;
    localparam int LOGLAT_DEF   = 4;

    // Value of rst that holds the block in reset.
    localparam logic RST_ACTIVE = 1'b0;

endpackage : s_wb_sched_pkg

// File: rtl/s_wb_chain.sv
// s_wb_chain -- writeback timing chain.
// A MAX_LAT-deep shift register of {valid, dest, fu} slots moving one step
// toward slot 0 every cycle. A new entry is written in parallel at index
// L-1 of the post-shift image, so it reaches slot 0 exactly L cycles later.
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   ins_en_i              insert an entry this cycle (already hazard-checked)
//   ins_lat_i/dest_i/fu_i latency, destination register, producing unit
//   fu_result_i           flattened unit results, unit n at [n*WIDTH +: WIDTH]
//   slot_vld_o            valid bit of every slot (for bus-conflict checks)
//   slot0_dest_o          registered write address (0 when slot 0 is empty)
//   wr_data_o             selected unit result for slot 0 (0 when empty)
module s_wb_chain
    import s_wb_sched_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int LOGDEPTH = LOGDEPTH_DEF,
    parameter int NUM_FU   = NUM_FU_DEF,
    parameter int LOGFU    = LOGFU_DEF,
    parameter int LOGLAT   = LOGLAT_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    ins_en_i,
    input  logic [LOGLAT-1:0]       ins_lat_i,
    input  logic [LOGDEPTH-1:0]     ins_dest_i,
    input  logic [LOGFU-1:0]        ins_fu_i,
    input  logic [NUM_FU*WIDTH-1:0] fu_result_i,
    output logic [(2**LOGLAT)-2:0]  slot_vld_o,
    output logic [LOGDEPTH-1:0]     slot0_dest_o,
    output logic [WIDTH-1:0]        wr_data_o
);

    localparam int MAX_LAT = (2**LOGLAT) - 1;

    logic [MAX_LAT-1:0]                vld_q, vld_d;
    logic [MAX_LAT-1:0][LOGDEPTH-1:0]  dest_q, dest_d;
    logic [MAX_LAT-1:0][LOGFU-1:0]     fu_q, fu_d;

    // Next chain image: shift toward slot 0, then drop the new entry at L-1.
    // Empty slots carry zero fields so slot 0's dest doubles as wr_addr.
    always_comb begin
        vld_d  = '0;
        dest_d = '0;
        fu_d   = '0;
        for (int i = 0; i < MAX_LAT - 1; i++) begin
            vld_d[i]  = vld_q[i+1];
            dest_d[i] = dest_q[i+1];
            fu_d[i]   = fu_q[i+1];
        end
        if (ins_en_i) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                if (ins_lat_i == LOGLAT'(i + 1)) begin
                    vld_d[i]  = 1'b1;
                    dest_d[i] = ins_dest_i;
                    fu_d[i]   = ins_fu_i;
                end else begin
                    vld_d[i]  = vld_d[i];
                end
            end
        end else begin
            vld_d = vld_d;
        end
    end

    // Chain state register; reset discards every in-flight writeback.
    always_ff @(posedge clk_i) begin
        if (rst_n_i == RST_ACTIVE) begin
            vld_q  <= '0;
            dest_q <= '0;
            fu_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            dest_q <= dest_d;
            fu_q   <= fu_d;
        end
    end

    assign slot_vld_o   = vld_q;
    assign slot0_dest_o = dest_q[0];

    // Result data is taken from the unit in the writeback cycle itself.
    always_comb begin
        if (vld_q[0]) begin
            wr_data_o = fu_result_i[fu_q[0]*WIDTH +: WIDTH];
        end else begin
            wr_data_o = '0;
        end
    end

endmodule : s_wb_chain

// File: rtl/s_wb_sched.sv
// s_wb_sched -- scalar result writeback scheduler (S register write port).
// Accepts an issue only when its writeback slot is free and no RAW/WAW
// hazard is outstanding, tracks per-register pending writes, and drives the
// register file write port from the timing chain.
// Ports:
//   clk, rst (sync, active-low)
//   i_issue_vld / o_issue_rdy       issue handshake (rdy combinational)
//   i_issue_dest/fu/lat             destination, producing unit, latency
//   i_src_j/k_addr, i_src_j/k_used  source operands of the issuing op
//   i_fu_result                     flattened unit results
//   o_wr_addr/o_wr_data/o_wr_en     register file write port
//   o_busy                          per-register pending-write bits
//   o_stall_cnt                     stalled-request counter (SWB_STALL_CNT_EN)
// Optional build macro: SWB_STALL_CNT_EN.
module s_wb_sched
    import s_wb_sched_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int LOGDEPTH = LOGDEPTH_DEF,
    parameter int NUM_FU   = NUM_FU_DEF,
    parameter int LOGFU    = LOGFU_DEF,
    parameter int LOGLAT   = LOGLAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_issue_vld,
    output logic                    o_issue_rdy,
    input  logic [LOGDEPTH-1:0]     i_issue_dest,
    input  logic [LOGFU-1:0]        i_issue_fu,
    input  logic [LOGLAT-1:0]       i_issue_lat,
    input  logic [LOGDEPTH-1:0]     i_src_j_addr,
    input  logic [LOGDEPTH-1:0]     i_src_k_addr,
    input  logic                    i_src_j_used,
    input  logic                    i_src_k_used,
    input  logic [NUM_FU*WIDTH-1:0] i_fu_result,
    output logic [LOGDEPTH-1:0]     o_wr_addr,
    output logic [WIDTH-1:0]        o_wr_data,
    output logic                    o_wr_en,
    output logic [(2**LOGDEPTH)-1:0] o_busy
`ifdef SWB_STALL_CNT_EN
    ,
    output logic [31:0]             o_stall_cnt
`endif
);

    localparam int DEPTH   = 2**LOGDEPTH;
    localparam int MAX_LAT = (2**LOGLAT) - 1;

    logic [MAX_LAT-1:0] slot_vld_s;
    logic [DEPTH-1:0]   busy_q, busy_d;
    logic               lat_ok_s;
    logic               conflict_s;
    logic               dest_ok_s;
    logic               src_j_ok_s;
    logic               src_k_ok_s;

    // A busy register is still usable when its write lands this very cycle;
    // the register file forwards wr_data to same-cycle reads.
    function automatic logic reg_free(input logic [DEPTH-1:0]    busy,
                                      input logic [LOGDEPTH-1:0] r,
                                      input logic                wen,
                                      input logic [LOGDEPTH-1:0] waddr);
        return !busy[r] || (wen && (waddr == r));
    endfunction

    s_wb_chain #(
        .WIDTH    (WIDTH),
        .LOGDEPTH (LOGDEPTH),
        .NUM_FU   (NUM_FU),
        .LOGFU    (LOGFU),
        .LOGLAT   (LOGLAT)
    ) u_chain (
        .clk_i        (clk),
        .rst_n_i      (rst),
        .ins_en_i     (o_issue_rdy),
        .ins_lat_i    (i_issue_lat),
        .ins_dest_i   (i_issue_dest),
        .ins_fu_i     (i_issue_fu),
        .fu_result_i  (i_fu_result),
        .slot_vld_o   (slot_vld_s),
        .slot0_dest_o (o_wr_addr),
        .wr_data_o    (o_wr_data)
    );

    assign o_wr_en = slot_vld_s[0];

    // Result-bus conflict: the slot now at index L shifts to L-1 and would
    // collide with the new entry. Nothing sits beyond the last slot.
    always_comb begin
        conflict_s = 1'b0;
        if (i_issue_lat < LOGLAT'(MAX_LAT)) begin
            conflict_s = slot_vld_s[i_issue_lat];
        end else begin
            conflict_s = 1'b0;
        end
    end

    assign lat_ok_s   = (i_issue_lat != {LOGLAT{1'b0}});
    assign dest_ok_s  = reg_free(busy_q, i_issue_dest, o_wr_en, o_wr_addr);
    assign src_j_ok_s = !i_src_j_used || reg_free(busy_q, i_src_j_addr, o_wr_en, o_wr_addr);
    assign src_k_ok_s = !i_src_k_used || reg_free(busy_q, i_src_k_addr, o_wr_en, o_wr_addr);

    assign o_issue_rdy = i_issue_vld && lat_ok_s && !conflict_s &&
                         dest_ok_s && src_j_ok_s && src_k_ok_s;

    // Busy next state: clear on writeback, then set on issue (set wins).
    always_comb begin
        busy_d = busy_q;
        if (o_wr_en) begin
            busy_d[o_wr_addr] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (o_issue_rdy) begin
            busy_d[i_issue_dest] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;

`ifdef SWB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles a request was presented but refused.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            stall_cnt_q <= 32'd0;
        end else if (i_issue_vld && !o_issue_rdy && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule : s_wb_sched
